router_pkt_tx: RTL and testbench
================================

// Module: router_pkt_tx
// PURPOSE
//  Packet source for the 1x3 router input port: the transmitting end of the router's byte-serial packet protocol.
//  Gathers one payload into a local buffer, then sends header, payload and parity back-to-back on data_out/pkt_valid.
//  Honours the router's busy back-pressure. Sits in front of the router's input port in the top level and in test harnesses.
// PARAMETERS
//  MAX_LEN    63   maximum payload bytes; sets buffer depth (fixed by the 6-bit length field)
//  GAP_CYC    1    idle cycles, pkt_valid=0, between a parity byte and the next header
// PORTS
//  clock       in   1  system clock, rising edge
//  resetn      in   1  synchronous, active-low reset
//  start       in   1  request a packet; sampled only in IDLE
//  dest_addr   in   2  destination port 0..2; value 3 is illegal
//  pay_len     in   6  payload length 1..63; value 0 is illegal
//  pl_data     in   8  payload byte from upstream
//  pl_valid    in   1  pl_data valid
//  pl_ready    out  1  block accepts pl_data this cycle
//  busy        in   1  router back-pressure; 1 = hold current byte
//  data_out    out  8  byte to router
//  pkt_valid   out  1  1 during header+payload, 0 during parity byte and idle
//  tx_active   out  1  high from start acceptance through end of GAP
//  done        out  1  one-cycle pulse when the parity byte is accepted
//  err_inject  in   1  request corrupt parity; used only with ROUTER_TX_ERR_INJECT_EN
// BEHAVIOUR
//  Reset (resetn=0 at clock edge): state=IDLE; data_out=0, pkt_valid=0, pl_ready=0, tx_active=0, done=0.
//   Buffer pointers and parity accumulator clear. Reset mid-packet aborts it; the next start is accepted normally.
//  A byte is "accepted" on any rising edge where the state drives it and busy=0. All outputs are registered.
//  IDLE:    start=1 & pay_len!=0 & dest_addr!=3 -> capture header = {pay_len, dest_addr}; wr_ptr=0 -> LOAD.
//           Illegal start is ignored silently: no done, state unchanged.
//  LOAD:    pl_ready=1; each pl_valid=1 cycle writes pl_data at wr_ptr, wr_ptr++.
//           After write of byte pay_len-1 -> HEADER. pl_ready drops the cycle after the last write.
//  HEADER:  data_out=header, pkt_valid=1. Parity acc = header. On accept -> PAYLOAD with rd_ptr=0.
//  PAYLOAD: data_out=buf[rd_ptr], pkt_valid=1. On accept: acc ^= byte, rd_ptr++.
//           After byte pay_len-1 is accepted -> PARITY. No bubbles: pkt_valid never drops inside a packet.
//  PARITY:  data_out=acc (header ^ all payload), pkt_valid=0. On accept: done=1 for 1 cycle -> GAP.
//  GAP:     pkt_valid=0, data_out=0 for GAP_CYC cycles, which gives the router a detect-address cycle -> IDLE.
//  busy=1 in HEADER/PAYLOAD/PARITY: data_out, pkt_valid, pointers and acc frozen. busy is ignored in IDLE/LOAD/GAP.
//  start while not IDLE is ignored; it is not queued.
//  Pointers are 6-bit; pay_len=63 uses addresses 0..62; no wrap occurs.
//  Arithmetic: parity is a bytewise XOR, 8-bit, no carry.
// CONFIGURATION
//  ROUTER_TX_ERR_INJECT_EN defined: err_inject sampled with an accepted start.
//   If err_inject=1, that packet's parity byte goes out as acc ^ 8'h01.
//  Not defined: err_inject is ignored; parity is always correct.
// STRUCTURE
//  Shared package router_pkg:
//   tx state enum (IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP)
//   ADDR_W=2, LEN_W=6, DATA_W=8, ILLEGAL_ADDR=2'd3
//  Sub-module router_tx_buf: 64x8 single-port-write / async-read register array with wr_ptr/rd_ptr.
//   The top level holds the FSM, header register and parity accumulator.
// TESTING
//  1 addr=2, len=3, payload 11,22,33, busy=0 -> data_out 0E,11,22,33 with pkt_valid=1, then 0E with pkt_valid=0; done pulses once.
//  2 Same packet, busy=1 for 4 cycles while 22 is on data_out -> 22 and pkt_valid held; output sequence unchanged.
//  3 len=0, or addr=3 -> no pl_ready, tx_active=0, no output; a following legal start works.
//  4 len=63, pl_valid toggling 50% -> all 63 bytes sent in order; parity = XOR of header and payload; pl_ready=0 after byte 63.
//  5 resetn=0 during PAYLOAD -> next cycle all outputs 0, state IDLE; a fresh packet completes correctly.
//  6 With ROUTER_TX_ERR_INJECT_EN, test 1 plus err_inject=1 -> parity byte 0F; without the macro -> 0E.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned DATA_W = 8;
    localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHeader,
        StPayload,
        StParity,
        StGap
    } tx_state_e;

    function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: synchronous write, asynchronous read, with its own write/read pointers.
module router_tx_buf
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_clr,
    input  logic              rd_inc,
    output logic [LEN_W-1:0]  wr_ptr,
    output logic [LEN_W-1:0]  rd_ptr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn || wr_clr) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + LEN_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn || rd_clr) begin
            rd_ptr <= '0;
        end else if (rd_inc) begin
            rd_ptr <= rd_ptr + LEN_W'(1);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_pkt_tx.sv
// Byte-serial packet source for the router input port: header, payload, parity.
// Optional corrupt-parity injection is enabled by defining ROUTER_TX_ERR_INJECT_EN.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned MAX_LEN = 63,
    parameter int unsigned GAP_CYC = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  pay_len,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              pkt_valid,
    output logic              tx_active,
    output logic              done,
    input  logic              err_inject
);

    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    tx_state_e         state;
    logic [DATA_W-1:0] header;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0] par_mask;
    logic [GAP_W-1:0]  gap_cnt;
    logic [LEN_W-1:0]  hdr_len;
    logic [LEN_W-1:0]  wr_ptr;
    logic [LEN_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              start_ok;
    logic              wr_en;
    logic              rd_inc;
    logic              last_wr;
    logic              last_pl;

    assign hdr_len  = header[DATA_W-1 -: LEN_W];
    assign start_ok = (state == StIdle) && start && (pay_len != '0) && (dest_addr != ILLEGAL_ADDR);
    assign wr_en    = (state == StLoad) && pl_valid && pl_ready;
    assign last_wr  = (wr_ptr == hdr_len - LEN_W'(1));
    // rd_ptr runs one ahead of data_out, so the last byte is on the wire when rd_ptr == length
    assign last_pl  = (rd_ptr == hdr_len);
    assign rd_inc   = !busy && ((state == StHeader) || ((state == StPayload) && !last_pl));
    assign acc_nxt  = acc ^ data_out;

`ifdef ROUTER_TX_ERR_INJECT_EN
    logic err_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= err_inject;
        end
    end

    assign par_mask = {{(DATA_W-1){1'b0}}, err_q};
`else
    logic unused_err_inject;
    assign unused_err_inject = err_inject;
    assign par_mask = '0;
`endif

    router_tx_buf #(
        .DEPTH (MAX_LEN + 1)
    ) u_buf (
        .clock   (clock),
        .resetn  (resetn),
        .wr_clr  (state == StIdle),
        .wr_en   (wr_en),
        .wr_data (pl_data),
        .rd_clr  (state == StLoad),
        .rd_inc  (rd_inc),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= StIdle;
            data_out  <= '0;
            pkt_valid <= 1'b0;
            pl_ready  <= 1'b0;
            tx_active <= 1'b0;
            done      <= 1'b0;
            header    <= '0;
            acc       <= '0;
            gap_cnt   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start_ok) begin
                        header    <= make_header(pay_len, dest_addr);
                        pl_ready  <= 1'b1;
                        tx_active <= 1'b1;
                        state     <= StLoad;
                    end
                end
                StLoad: begin
                    if (wr_en && last_wr) begin
                        pl_ready  <= 1'b0;
                        data_out  <= header;
                        pkt_valid <= 1'b1;
                        acc       <= header;
                        state     <= StHeader;
                    end
                end
                StHeader: begin
                    if (!busy) begin
                        data_out <= rd_data;
                        state    <= StPayload;
                    end
                end
                StPayload: begin
                    if (!busy) begin
                        acc <= acc_nxt;
                        if (last_pl) begin
                            data_out  <= acc_nxt ^ par_mask;
                            pkt_valid <= 1'b0;
                            state     <= StParity;
                        end else begin
                            data_out <= rd_data;
                        end
                    end
                end
                StParity: begin
                    if (!busy) begin
                        done     <= 1'b1;
                        data_out <= '0;
                        gap_cnt  <= '0;
                        state    <= StGap;
                    end
                end
                StGap: begin
                    if (gap_cnt == GAP_LAST) begin
                        tx_active <= 1'b0;
                        state     <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx; expected bytes are queued at stimulus time.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_active;
    logic       done;
    logic       err_inject;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] sb [$];
    logic       par_win   = 1'b0;
    logic       done_pend = 1'b0;

    router_pkt_tx dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .dest_addr  (dest_addr),
        .pay_len    (pay_len),
        .pl_data    (pl_data),
        .pl_valid   (pl_valid),
        .pl_ready   (pl_ready),
        .busy       (busy),
        .data_out   (data_out),
        .pkt_valid  (pkt_valid),
        .tx_active  (tx_active),
        .done       (done),
        .err_inject (err_inject)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1, so negedge values are what the next edge samples.
    always @(negedge clock) begin
        if (!resetn) begin
            par_win   = 1'b0;
            done_pend = 1'b0;
        end else begin
            if (done || done_pend) check_eq("done_pulse", {31'd0, done}, {31'd0, done_pend});
            done_pend = 1'b0;
            if (pkt_valid && !busy) begin
                if (sb.size() == 0) check_eq("sb_underflow", sb.size(), 1);
                else check_eq("tx_byte", {23'd0, pkt_valid, data_out}, {23'd0, sb.pop_front()});
                par_win = 1'b1;
            end else if (!pkt_valid && par_win && !busy) begin
                if (sb.size() == 0) check_eq("sb_underflow", sb.size(), 1);
                else check_eq("parity", {23'd0, pkt_valid, data_out}, {23'd0, sb.pop_front()});
                par_win   = 1'b0;
                done_pend = 1'b1;
            end
        end
    end

    task automatic run_pkt(input logic [1:0] addr, input logic [5:0] len, input bit toggle_pv,
                           input logic [7:0] hold_byte, input int hold_cycles, input logic inj,
                           input int abort_cyc);
        logic [7:0] pl [64];
        logic [7:0] hdr;
        logic [7:0] par;
        int         idx;
        int         cyc;
        int         held;
        bit         acc_now;
        hdr = {len, addr};
        par = hdr;
        sb.push_back({1'b1, hdr});
        for (int k = 0; k < int'(len); k++) begin
            pl[k] = (len == 6'd3) ? 8'(8'h11 * (k + 1)) : 8'($urandom_range(0, 255));
            par ^= pl[k];
            sb.push_back({1'b1, pl[k]});
        end
`ifdef ROUTER_TX_ERR_INJECT_EN
        if (inj) par ^= 8'h01;
`endif
        sb.push_back({1'b0, par});

        @(posedge clock); #1;
        start = 1'b1; dest_addr = addr; pay_len = len; err_inject = inj;
        @(posedge clock); #1;
        start = 1'b0; err_inject = 1'b0;
        check_eq("load_ready", {31'd0, pl_ready}, 32'd1);
        check_eq("load_active", {31'd0, tx_active}, 32'd1);

        idx = 0;
        cyc = 0;
        while (idx < int'(len) && cyc < 1000) begin
            pl_valid = toggle_pv ? 1'($urandom_range(0, 1)) : 1'b1;
            pl_data  = pl[idx];
            @(negedge clock);
            acc_now = pl_valid && pl_ready;
            @(posedge clock); #1;
            if (acc_now) idx++;
            cyc++;
        end
        pl_valid = 1'b0;
        check_eq("load_count", idx, int'(len));
        check_eq("ready_drop", {31'd0, pl_ready}, 32'd0);

        cyc  = 0;
        held = 0;
        while (!done && cyc < 500) begin
            if (abort_cyc > 0 && cyc == abort_cyc) begin
                resetn = 1'b0;
                @(posedge clock); #1;
                check_eq("abort_outs", {27'd0, data_out, pkt_valid, pl_ready, tx_active, done},
                         32'd0);
                resetn = 1'b1;
                busy   = 1'b0;
                sb.delete();
                return;
            end
            busy = pkt_valid && (data_out == hold_byte) && (held < hold_cycles);
            if (busy) held++;
            @(posedge clock); #1;
            if (busy) check_eq("busy_hold", {23'd0, pkt_valid, data_out}, {23'd0, 1'b1, hold_byte});
            cyc++;
        end
        busy = 1'b0;
        check_eq("done_seen", {31'd0, done}, 32'd1);
        check_eq("hold_count", held, hold_cycles);
        check_eq("gap_active", {31'd0, tx_active}, 32'd1);
        check_eq("gap_data", {23'd0, pkt_valid, data_out}, 32'd0);
        @(posedge clock); #1;
        check_eq("idle_active", {31'd0, tx_active}, 32'd0);
        check_eq("sb_drained", sb.size(), 0);
    endtask

    task automatic try_illegal(input logic [1:0] addr, input logic [5:0] len);
        @(posedge clock); #1;
        start = 1'b1; dest_addr = addr; pay_len = len;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("illegal_outs", {29'd0, pl_ready, tx_active, pkt_valid}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; dest_addr = '0; pay_len = '0;
        pl_data = '0; pl_valid = 1'b0; busy = 1'b0; err_inject = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("reset_outs", {27'd0, data_out, pkt_valid, pl_ready, tx_active, done}, 32'd0);
        resetn = 1'b1;

        run_pkt(2'd2, 6'd3, 1'b0, 8'h00, 0, 1'b0, 0);
        run_pkt(2'd2, 6'd3, 1'b0, 8'h22, 4, 1'b0, 0);
        try_illegal(2'd1, 6'd0);
        try_illegal(2'd3, 6'd4);
        run_pkt(2'd1, 6'd5, 1'b0, 8'h00, 0, 1'b0, 0);
        run_pkt(2'd0, 6'd63, 1'b1, 8'h00, 0, 1'b0, 0);
        run_pkt(2'd1, 6'd10, 1'b0, 8'h00, 0, 1'b0, 3);
        run_pkt(2'd0, 6'd7, 1'b1, 8'h00, 0, 1'b0, 0);
        run_pkt(2'd2, 6'd3, 1'b0, 8'h00, 0, 1'b1, 0);
        run_pkt(2'd2, 6'd1, 1'b0, 8'h00, 0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
